// File: rtl/branch_resolve_tracker_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : shared branch-tracking types for fetch, execute and retire
// Revision   : 1.0
// ============================================================================
package branch_pkg;

    localparam int BHT_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic [BHT_IDX_W-1:0] idx;
        logic                 pred;
        logic                 taken;
    } bt_entry_t;

    // A resolved entry whose outcome disagrees with its prediction.
    function automatic logic is_mispredict(input bt_entry_t e);
        return e.valid & e.resolved & (e.taken != e.pred);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_tracker_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit up counter that sticks at all-ones
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         incr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (incr_i && !(&r_count)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_tracker.sv
`default_nettype none
// ============================================================================
// branch_resolve_tracker : in-order retirement of out-of-order resolved
//                          branches, driving predictor training and flushes
// Revision               : 1.0
// ============================================================================
module branch_resolve_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3,
    parameter int IDX_W = BHT_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             alloc_v_i,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  logic             alloc_pred_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             resolve_v_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_taken_i,
    output logic             anUpdate_o,
    output logic [IDX_W-1:0] branchAddrWrite_o,
    output logic             brTaken_o,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] mispredCount_o
);

    localparam logic [TAG_W:0] c_FULL_CNT = (TAG_W+1)'(DEPTH);

    bt_entry_t        r_entries [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    bt_entry_t        w_head;
    logic             w_pop;
    logic             w_flush;
    logic             w_alloc;
    logic             w_resolve_hit;

    assign w_head        = r_entries[r_head];
    assign w_pop         = w_head.valid & w_head.resolved;
    assign w_flush       = is_mispredict(w_head);
    assign alloc_ready_o = (r_count < c_FULL_CNT) & ~w_flush;
    assign alloc_tag_o   = r_tail;
    assign w_alloc       = alloc_v_i & alloc_ready_o;
    assign w_resolve_hit = resolve_v_i & r_entries[resolve_tag_i].valid
                         & ~r_entries[resolve_tag_i].resolved;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            anUpdate_o        <= 1'b0;
            mispredict_o      <= 1'b0;
            brTaken_o         <= 1'b0;
            branchAddrWrite_o <= '0;
        end else begin
            anUpdate_o   <= w_pop;
            mispredict_o <= w_flush;
            if (w_pop) begin
                branchAddrWrite_o <= w_head.idx;
                brTaken_o         <= w_head.taken;
            end

            if (w_flush) begin
                // Everything younger than the mispredicted branch is wrong-path.
                for (int i = 0; i < DEPTH; i++) begin
                    r_entries[i].valid <= 1'b0;
                end
                r_head  <= r_head + TAG_W'(1);
                r_tail  <= r_head + TAG_W'(1);
                r_count <= '0;
            end else begin
                if (w_resolve_hit) begin
                    r_entries[resolve_tag_i].resolved <= 1'b1;
                    r_entries[resolve_tag_i].taken    <= resolve_taken_i;
                end
                if (w_pop) begin
                    r_entries[r_head].valid <= 1'b0;
                    r_head                  <= r_head + TAG_W'(1);
                end
                if (w_alloc) begin
                    r_entries[r_tail] <= '{valid:    1'b1,
                                           resolved: 1'b0,
                                           idx:      alloc_idx_i,
                                           pred:     alloc_pred_i,
                                           taken:    1'b0};
                    r_tail            <= r_tail + TAG_W'(1);
                end
                case ({w_alloc, w_pop})
                    2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                    2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_mispred_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .incr_i  (w_flush),
        .count_o (mispredCount_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_tracker.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_tracker : directed and random checks against a
//                             program-order queue model of the tracker
// Revision                  : 1.0
// ============================================================================
module tb_branch_resolve_tracker;

    localparam int DEPTH   = 8;
    localparam int TAG_W   = 3;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_v = 1'b0;
    logic [IDX_W-1:0] alloc_idx = '0;
    logic             alloc_pred = 1'b0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             resolve_v = 1'b0;
    logic [TAG_W-1:0] resolve_tag = '0;
    logic             resolve_taken = 1'b0;
    logic             an_update;
    logic [IDX_W-1:0] br_addr;
    logic             br_taken;
    logic             mispredict;
    logic [CNT_W-1:0] mis_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_tracker #(
        .DEPTH (DEPTH), .TAG_W (TAG_W), .IDX_W (IDX_W), .CNT_W (CNT_W)
    ) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .alloc_v_i         (alloc_v),
        .alloc_idx_i       (alloc_idx),
        .alloc_pred_i      (alloc_pred),
        .alloc_ready_o     (alloc_ready),
        .alloc_tag_o       (alloc_tag),
        .resolve_v_i       (resolve_v),
        .resolve_tag_i     (resolve_tag),
        .resolve_taken_i   (resolve_taken),
        .anUpdate_o        (an_update),
        .branchAddrWrite_o (br_addr),
        .brTaken_o         (br_taken),
        .mispredict_o      (mispredict),
        .mispredCount_o    (mis_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: in-flight branches in program order
    typedef struct {
        int tag;
        int idx;
        bit pred;
        bit res;
        bit taken;
    } br_t;

    br_t q[$];
    int  m_tail  = 0;
    bit  e_upd   = 0;
    bit  e_mis   = 0;
    bit  e_taken = 0;
    int  e_addr  = 0;
    int  e_cnt   = 0;

    function automatic bit m_flush_now();
        return (q.size() > 0) && q[0].res && (q[0].taken != q[0].pred);
    endfunction

    function automatic bit m_ready();
        return (q.size() < DEPTH) && !m_flush_now();
    endfunction

    always @(posedge clk or posedge rst) begin : model_step
        bit  pop, fl, acc;
        br_t h;
        if (rst) begin
            q.delete();
            m_tail = 0; e_upd = 0; e_mis = 0; e_taken = 0; e_addr = 0; e_cnt = 0;
        end else begin
            pop = (q.size() > 0) && q[0].res;
            fl  = m_flush_now();
            acc = alloc_v && m_ready();
            e_upd = 0;
            e_mis = 0;
            h = '{0, 0, 0, 0, 0};
            if (pop) begin
                h       = q.pop_front();
                e_upd   = 1;
                e_addr  = h.idx;
                e_taken = h.taken;
                e_mis   = (h.taken != h.pred);
            end
            if (fl) begin
                q.delete();
                m_tail = (h.tag + 1) % DEPTH;
                if (e_cnt < CNT_MAX) e_cnt++;
            end else begin
                if (resolve_v) begin
                    foreach (q[i]) begin
                        if (q[i].tag == int'(resolve_tag) && !q[i].res) begin
                            q[i].res   = 1;
                            q[i].taken = resolve_taken;
                        end
                    end
                end
                if (acc) begin
                    q.push_back('{m_tail, int'(alloc_idx), alloc_pred, 1'b0, 1'b0});
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m.ready",   int'(alloc_ready), int'(m_ready()));
        chk("m.tag",     int'(alloc_tag),   m_tail);
        chk("m.update",  int'(an_update),   int'(e_upd));
        chk("m.mispred", int'(mispredict),  int'(e_mis));
        chk("m.addr",    int'(br_addr),     e_addr);
        chk("m.taken",   int'(br_taken),    int'(e_taken));
        chk("m.count",   int'(mis_cnt),     e_cnt);
    end

    // ---------------- stimulus
    task automatic step(input bit av, input int aidx, input bit ap,
                        input bit rv, input int rtag, input bit rt);
        alloc_v       = av;
        alloc_idx     = IDX_W'(aidx);
        alloc_pred    = ap;
        resolve_v     = rv;
        resolve_tag   = TAG_W'(rtag);
        resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        alloc_v   = 1'b0;
        resolve_v = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("rst.ready", int'(alloc_ready), 1);
            chk("rst.tag",   int'(alloc_tag),   0);
            chk("rst.upd",   int'(an_update),   0);
            chk("rst.cnt",   int'(mis_cnt),     0);
            idle();
        end

        // Single correctly predicted branch
        step(1, 4, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("t2.upd_early", int'(an_update), 0);
        idle();
        chk("t2.upd",  int'(an_update),  1);
        chk("t2.addr", int'(br_addr),    4);
        chk("t2.tkn",  int'(br_taken),   1);
        chk("t2.mis",  int'(mispredict), 0);

        // Reverse-order resolution retires in program order
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("t3.none", int'(an_update), 0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("t3.upd",  int'(an_update), 1);
            chk("t3.addr", int'(br_addr),   i);
        end
        idle();
        chk("t3.done", int'(an_update), 0);

        // Full, refused alloc, wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0, 0);
        chk("t4.full", int'(alloc_ready), 0);
        chk("t4.tag",  int'(alloc_tag),   0);
        step(1, 9, 0, 0, 0, 0);
        chk("t4.refused", int'(alloc_ready), 0);
        step(1, 9, 0, 1, 0, 0);
        chk("t4.still_full", int'(alloc_ready), 0);
        step(1, 9, 0, 0, 0, 0);
        chk("t4.popped", int'(an_update),   1);
        chk("t4.ready",  int'(alloc_ready), 1);
        chk("t4.wrap",   int'(alloc_tag),   0);
        step(1, 20, 0, 0, 0, 0);
        chk("t4.next_tag", int'(alloc_tag),   1);
        chk("t4.full2",    int'(alloc_ready), 0);

        // Mispredict flush
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 10 + i, 1, 0, 0, 0);
        step(0, 0, 0, 1, 2, 1);
        step(1, 30, 0, 1, 0, 0);
        chk("t5.block", int'(alloc_ready), 0);
        step(1, 30, 0, 1, 3, 1);
        chk("t5.upd",   int'(an_update),   1);
        chk("t5.mis",   int'(mispredict),  1);
        chk("t5.addr",  int'(br_addr),     10);
        chk("t5.cnt",   int'(mis_cnt),     1);
        chk("t5.tag",   int'(alloc_tag),   1);
        chk("t5.ready", int'(alloc_ready), 1);
        step(0, 0, 0, 1, 2, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t5.dropped", int'(an_update), 0);
        end

        // Asynchronous reset with entries in flight
        do_reset();
        for (int i = 0; i < 5; i++) step(1, i + 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 1, 1);
        chk("t6.pre_upd", int'(an_update), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6.upd0",  int'(an_update),   0);
        chk("t6.addr0", int'(br_addr),     0);
        chk("t6.tag0",  int'(alloc_tag),   0);
        chk("t6.rdy",   int'(alloc_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t6.quiet", int'(an_update), 0);
        end

        // Random traffic, mostly correct predictions so the queue fills
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit p, t;
            p = 1'($urandom_range(0, 1));
            t = ($urandom_range(0, 9) < 8) ? p : ~p;
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)), p,
                 $urandom_range(0, 9) < 6, int'($urandom_range(0, DEPTH - 1)), t);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
